// File: rtl/note_scroller.sv
// Rhythm-game note track: 16-slot scroller with hit-zone judging, score and combo.
// Optional macro NOTE_SCROLLER_COMBO_EN enables the combo counter (otherwise combo reads 0).
module note_scroller (
   input  logic        clock,
   input  logic        reset_b,
   input  logic        tick,
   input  logic        start,
   input  logic [1:0]  chart_data,
   input  logic        chart_valid,
   input  logic        chart_last,
   output logic        chart_ready,
   input  logic        hit_don,
   input  logic        hit_ka,
   output logic [31:0] track_view,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        underrun,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  r_state, w_state_nxt;
   logic [31:0] r_track, w_track_judged, w_track_nxt;
   logic [15:0] r_score;
   logic        r_hit, r_miss, r_underrun;

   logic        w_active, w_start, w_key, w_match, w_clear;
   logic        w_hit, w_miss, w_tick, w_shift_miss, w_accept;
   logic [1:0]  w_slot0, w_new;

   assign w_active    = (r_state == S_PLAY) || (r_state == S_DRAIN);
   assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign chart_ready = tick && (r_state == S_PLAY);
   assign w_accept    = chart_valid && chart_ready;
   assign w_tick      = tick && w_active;

   // Judging uses the pre-shift hit zone; hit_don wins when both keys pulse.
   assign w_slot0      = r_track[1:0];
   assign w_key        = w_active && (hit_don || hit_ka);
   assign w_match      = hit_don ? (w_slot0 == 2'b01) : (w_slot0 == 2'b10);
   assign w_clear      = w_key && (w_slot0 != 2'b00);
   assign w_hit        = w_clear && w_match;
   assign w_shift_miss = w_tick && (w_slot0 != 2'b00) && !w_clear;
   assign w_miss       = (w_clear && !w_match) || w_shift_miss;

   // Code 11 is loaded as empty so the track only ever holds 00/01/10.
   assign w_new = (w_accept && ((chart_data == 2'b01) || (chart_data == 2'b10)))
                  ? chart_data : 2'b00;

   assign w_track_judged = w_clear ? {r_track[31:2], 2'b00} : r_track;
   assign w_track_nxt    = w_tick ? {w_new, w_track_judged[31:2]} : w_track_judged;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (w_start) w_state_nxt = S_PLAY;
         S_PLAY:         if (w_accept && chart_last) w_state_nxt = S_DRAIN;
         S_DRAIN:        if (w_track_nxt == 32'd0) w_state_nxt = S_DONE;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_state    <= S_IDLE;
         r_track    <= 32'd0;
         r_score    <= 16'd0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hit   <= w_hit;
         r_miss  <= w_miss;
         if (w_start) begin
            r_track    <= 32'd0;
            r_score    <= 16'd0;
            r_underrun <= 1'b0;
         end else begin
            r_track <= w_track_nxt;
            if (w_hit && (r_score != 16'hFFFF)) r_score <= r_score + 16'd1;
            if (w_tick && (r_state == S_PLAY) && !chart_valid) r_underrun <= 1'b1;
         end
      end
   end

`ifdef NOTE_SCROLLER_COMBO_EN
   logic [7:0] r_combo;

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b)                     r_combo <= 8'd0;
      else if (w_start || w_miss)       r_combo <= 8'd0;
      else if (w_hit && (r_combo != 8'hFF)) r_combo <= r_combo + 8'd1;
   end

   assign combo = r_combo;
`else
   assign combo = 8'h00;
`endif

   assign track_view = r_track;
   assign score      = r_score;
   assign hit_pulse  = r_hit;
   assign miss_pulse = r_miss;
   assign underrun   = r_underrun;
   assign busy       = w_active;
   assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_note_scroller.sv
// Directed self-checking bench for note_scroller: scroll, judging, end of song, reset.
module tb_note_scroller;

   logic        clock = 1'b0;
   logic        reset_b = 1'b0;
   logic        tick = 1'b0, start = 1'b0;
   logic [1:0]  chart_data = 2'b00;
   logic        chart_valid = 1'b0, chart_last = 1'b0;
   logic        chart_ready;
   logic        hit_don = 1'b0, hit_ka = 1'b0;
   logic [31:0] track_view;
   logic [15:0] score;
   logic [7:0]  combo;
   logic        hit_pulse, miss_pulse, underrun, busy, done;

   int total = 0;
   int bad   = 0;

`ifdef NOTE_SCROLLER_COMBO_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   note_scroller dut (
      .clock(clock), .reset_b(reset_b), .tick(tick), .start(start),
      .chart_data(chart_data), .chart_valid(chart_valid), .chart_last(chart_last),
      .chart_ready(chart_ready), .hit_don(hit_don), .hit_ka(hit_ka),
      .track_view(track_view), .score(score), .combo(combo),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .underrun(underrun),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ec(input int v);
      return CE ? 32'(v) : 32'd0;
   endfunction

   task automatic tk(input logic [1:0] d, input logic v, input logic l);
      tick = 1'b1; chart_data = d; chart_valid = v; chart_last = l;
      step();
      tick = 1'b0; chart_data = 2'b00; chart_valid = 1'b0; chart_last = 1'b0;
   endtask

   task automatic key(input logic d, input logic k);
      hit_don = d; hit_ka = k;
      step();
      hit_don = 1'b0; hit_ka = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst_track", track_view, 32'd0);
      chk("rst_score", {16'd0, score}, 32'd0);
      chk("rst_flags", {busy, done, underrun, hit_pulse, miss_pulse}, 5'b00000);
      #4 reset_b = 1'b1;
      step();
      tick = 1'b1; chart_valid = 1'b1; #1;
      chk("idle_ready", chart_ready, 1'b0);
      step();
      tick = 1'b0; chart_valid = 1'b0;
      chk("idle_tick_ignored", track_view, 32'd0);

      // basic scroll
      do_start();
      chk("start_busy", {busy, done}, 2'b10);
      tick = 1'b1; chart_valid = 1'b1; chart_data = 2'b01; #1;
      chk("play_ready", chart_ready, 1'b1);
      step();
      tick = 1'b0; chart_valid = 1'b0; chart_data = 2'b00;
      chk("scroll_t1", track_view, 32'h4000_0000);
      for (int i = 0; i < 15; i++) tk(2'b00, 1'b1, 1'b0);
      chk("scroll_t16", track_view, 32'h0000_0001);

      // hit
      key(1'b1, 1'b0);
      chk("hit_pulse", {hit_pulse, miss_pulse}, 2'b10);
      chk("hit_score", {16'd0, score}, 32'd1);
      chk("hit_combo", {24'd0, combo}, ec(1));
      chk("hit_clear", track_view, 32'd0);
      step();
      chk("hit_pulse_drop", hit_pulse, 1'b0);

      // combo build, wrong key, shift-out miss
      tk(2'b01, 1'b1, 1'b0); tk(2'b01, 1'b1, 1'b0); tk(2'b01, 1'b1, 1'b0);
      tk(2'b01, 1'b1, 1'b0); tk(2'b10, 1'b1, 1'b0); tk(2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) tk(2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         key(1'b1, 1'b0);
         tk(2'b00, 1'b1, 1'b0);
      end
      chk("combo5_score", {16'd0, score}, 32'd5);
      chk("combo5", {24'd0, combo}, ec(5));
      chk("ka_in_zone", {30'd0, track_view[1:0]}, 32'd2);
      key(1'b1, 1'b0);
      chk("wrong_key_pulse", {hit_pulse, miss_pulse}, 2'b01);
      chk("wrong_key_combo", {24'd0, combo}, 32'd0);
      chk("wrong_key_clear", {30'd0, track_view[1:0]}, 32'd0);
      tk(2'b00, 1'b1, 1'b0);
      chk("don_in_zone", {30'd0, track_view[1:0]}, 32'd1);
      tk(2'b00, 1'b1, 1'b0);
      chk("shift_miss", {hit_pulse, miss_pulse}, 2'b01);
      chk("shift_miss_score", {16'd0, score}, 32'd5);
      key(1'b0, 1'b1);
      chk("empty_key", {hit_pulse, miss_pulse}, 2'b00);
      chk("empty_key_score", {16'd0, score}, 32'd5);

      // coincidence, code 11 as empty, dual-key priority
      tk(2'b01, 1'b1, 1'b0); tk(2'b10, 1'b1, 1'b0); tk(2'b11, 1'b1, 1'b0);
      for (int i = 0; i < 13; i++) tk(2'b00, 1'b1, 1'b0);
      chk("coin_setup", track_view, 32'h0000_0009);
      hit_don = 1'b1; tick = 1'b1; chart_valid = 1'b1; chart_data = 2'b00;
      step();
      hit_don = 1'b0; tick = 1'b0; chart_valid = 1'b0;
      chk("coin_pulse", {hit_pulse, miss_pulse}, 2'b10);
      chk("coin_score", {16'd0, score}, 32'd6);
      chk("coin_combo", {24'd0, combo}, ec(1));
      chk("coin_shift", track_view, 32'h0000_0002);
      key(1'b1, 1'b1);
      chk("both_keys_pulse", {hit_pulse, miss_pulse}, 2'b01);
      chk("both_keys_combo", {24'd0, combo}, 32'd0);
      chk("both_keys_track", track_view, 32'd0);

      // underrun and end of song
      chk("underrun_pre", underrun, 1'b0);
      tk(2'b01, 1'b0, 1'b0);
      chk("underrun_set", underrun, 1'b1);
      chk("underrun_track", track_view, 32'd0);
      tk(2'b01, 1'b1, 1'b1);
      chk("drain_flags", {busy, done}, 2'b10);
      chk("drain_track", track_view, 32'h4000_0000);
      tick = 1'b1; chart_valid = 1'b1; #1;
      chk("drain_ready", chart_ready, 1'b0);
      step();
      tick = 1'b0; chart_valid = 1'b0;
      for (int i = 0; i < 14; i++) tk(2'b00, 1'b1, 1'b0);
      chk("drain_t15", track_view, 32'h0000_0001);
      chk("drain_t15_flags", {busy, done}, 2'b10);
      tk(2'b00, 1'b1, 1'b0);
      chk("done_flags", {busy, done}, 2'b01);
      chk("done_miss", miss_pulse, 1'b1);
      chk("done_underrun_sticky", underrun, 1'b1);
      tk(2'b01, 1'b1, 1'b0);
      chk("done_tick_ignored", track_view, 32'd0);

      // restart from DONE
      do_start();
      chk("restart_flags", {busy, done, underrun}, 3'b100);
      chk("restart_score", {16'd0, score}, 32'd0);

      // reset mid-song with score 3
      tk(2'b01, 1'b1, 1'b0); tk(2'b01, 1'b1, 1'b0); tk(2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 13; i++) tk(2'b00, 1'b1, 1'b0);
      key(1'b1, 1'b0); tk(2'b00, 1'b1, 1'b0);
      key(1'b1, 1'b0); tk(2'b00, 1'b1, 1'b0);
      key(1'b1, 1'b0);
      chk("pre_rst_score", {16'd0, score}, 32'd3);
      tk(2'b01, 1'b1, 1'b0);
      chk("pre_rst_track", track_view, 32'h4000_0000);
      #2 reset_b = 1'b0;
      tick = 1'b1; chart_valid = 1'b1; chart_data = 2'b10;
      #1;
      chk("async_rst_track", track_view, 32'd0);
      chk("async_rst_score", {16'd0, score}, 32'd0);
      chk("async_rst_combo", {24'd0, combo}, 32'd0);
      chk("async_rst_flags", {busy, done, underrun, hit_pulse, miss_pulse, chart_ready}, 6'd0);
      step();
      chk("rst_hold_track", track_view, 32'd0);
      tick = 1'b0; chart_valid = 1'b0; chart_data = 2'b00;
      #2 reset_b = 1'b1;
      step();
      chk("post_rst_idle", {busy, done}, 2'b00);
      do_start();
      chk("post_rst_start", {busy, done}, 2'b10);
      tk(2'b01, 1'b1, 1'b0);
      chk("post_rst_scroll", track_view, 32'h4000_0000);
      chk("post_rst_score", {16'd0, score}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_b  input  1  asynchronous active-low reset.
REQ-003 SHALL have port tick  input  1  one-cycle scroll pulse from the upstream rate divider.
REQ-004 SHALL have port start  input  1  begin song; honoured only in IDLE or DONE.
REQ-005 SHALL have port chart_data  input  2  next chart note: 00 empty, 01 don, 10 ka, 11 treated as empty.
REQ-006 SHALL have port chart_valid  input  1  chart_data/chart_last valid.
REQ-007 SHALL have port chart_last  input  1  current chart entry is the final one.
REQ-008 SHALL have port chart_ready  output  1  combinational: tick AND state==PLAY.
REQ-009 SHALL have ports hit_don, hit_ka  input  1 each  one-cycle player key pulses.
REQ-010 SHALL have port track_view  output  32  16 slots x 2 bits; slot 0 (hit zone) in bits 1:0.
REQ-011 SHALL have ports score  output  16, combo  output  8, hit_pulse  output  1, miss_pulse  output  1, underrun  output  1, busy  output  1, done  output  1.

Function
REQ-012 SHALL implement states IDLE, PLAY, DRAIN, DONE; busy=1 in PLAY/DRAIN, done=1 in DONE only.
REQ-013 SHALL, on start in IDLE or DONE, clear track, score, combo, underrun and enter PLAY next cycle.
REQ-014 SHALL ignore start in PLAY/DRAIN and ignore tick in IDLE/DONE.
REQ-015 SHALL, on tick in PLAY/DRAIN, shift track one slot toward slot 0 (slot n <= slot n+1); slot 15 loads the accepted chart entry, else 00.
REQ-016 SHALL accept a chart entry only when chart_valid AND chart_ready in the same cycle.
REQ-017 SHALL, on tick in PLAY with chart_valid=0, load 00 into slot 15 and set sticky underrun (cleared only by start or reset).
REQ-018 SHALL move PLAY->DRAIN on the cycle a chart entry with chart_last=1 is accepted.
REQ-019 SHALL move DRAIN->DONE on the first cycle all 16 slots are 00 after the last judge/shift.
REQ-020 SHALL judge keys only in PLAY/DRAIN; hit_don has priority when both keys pulse together (hit_ka ignored that cycle).
REQ-021 SHALL, on key matching slot 0, clear slot 0, pulse hit_pulse one cycle later, score +1 saturating at 16'hFFFF, combo +1 saturating at 8'hFF.
REQ-022 SHALL, on key with non-matching non-empty slot 0, clear slot 0, pulse miss_pulse, zero combo; key on empty slot 0 has no effect.
REQ-023 SHALL, on tick with non-empty slot 0 not cleared by a judge that cycle, pulse miss_pulse and zero combo as the note shifts out.
REQ-024 SHALL, when key and tick coincide, judge against pre-shift slot 0 first, then shift; a judged note SHALL NOT also count as shift-out miss.
REQ-025 SHALL register hit_pulse, miss_pulse, score, combo (one-cycle latency from key/tick); hit_pulse and miss_pulse never both high.

Reset
REQ-026 SHALL, while reset_b=0, asynchronously force state IDLE, track_view 0, score 0, combo 0, hit_pulse 0, miss_pulse 0, underrun 0, busy 0, done 0.
REQ-027 SHALL treat reset asserted mid-song as abandoning the song; no chart entry accepted while reset_b=0.

Configuration
REQ-028 SHALL, with macro NOTE_SCROLLER_COMBO_EN defined, implement the combo counter per REQ-021..023.
REQ-029 SHALL, without NOTE_SCROLLER_COMBO_EN, tie combo to 8'h00 and omit its register; all other behaviour unchanged.

Verification
REQ-030 SHALL cover basic scroll: start, chart don,empty x15,last empty; 16 ticks -> don reaches slot 0 after tick 16 (track_view[1:0]=01).
REQ-031 SHALL cover hit: don in slot 0, hit_don pulse -> hit_pulse=1 next cycle, score 0->1, combo 0->1, slot 0=00.
REQ-032 SHALL cover wrong key and shift-out: ka in slot 0 + hit_don -> miss_pulse, combo 5->0; unhit don at tick -> miss_pulse, score unchanged.
REQ-033 SHALL cover coincidence: hit_don and tick same cycle with don in slot 0 -> hit_pulse only, no miss_pulse, track shifted.
REQ-034 SHALL cover end/underrun: chart_valid low at a PLAY tick -> underrun=1; chart_last accepted -> DRAIN, 16 further ticks -> done=1, busy=0.
REQ-035 SHALL cover async reset mid-PLAY with score=3 -> all outputs 0 immediately, state IDLE, next start restarts cleanly.
